// File: rtl/pc_gen.sv
// Fetch-stage program counter generator: exception vectoring, redirect capture
// across stalls, and a circular return-address stack for call/return prediction.
module pc_gen #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0]   EXC_VEC     = 32'h0000_4180,
    parameter int                 INSTR_BYTES = 4,
    parameter int                 RAS_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         exc_valid,
    input  logic                         redirect_valid,
    input  logic [WIDTH-1:0]             redirect_pc,
    input  logic                         call_valid,
    input  logic [WIDTH-1:0]             link_addr,
    input  logic                         ret_pred,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             pc_plus,
    output logic                         pending,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_miss
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] pending_pc_q, pending_pc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             miss_q, miss_d;
    logic             push, pop;
    logic [WIDTH-1:0] ras_top;

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    assign pc_plus   = pc_q + WIDTH'(INSTR_BYTES);
    assign pc        = pc_q;
    assign pending   = pending_q;
    assign ras_count = count_q;
    assign ras_miss  = miss_q;

    // Pointer addresses the next free slot, so the top entry sits one below it.
    assign ras_top = ras_q[ptr_q - PW'(1)];

    // A call is recorded whenever its redirect is seen, even if it is only captured.
    assign push = redirect_valid & call_valid & ~exc_valid;

    always_comb begin
        pc_d         = pc_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        miss_d       = 1'b0;
        pop          = 1'b0;
        if (exc_valid) begin
            pc_d      = EXC_VEC;
            pending_d = 1'b0;
        end else if (redirect_valid && en) begin
            pc_d      = redirect_pc;
            pending_d = 1'b0;
        end else if (redirect_valid) begin
            pending_d    = 1'b1;
            pending_pc_d = redirect_pc;
        end else if (en && pending_q) begin
            pc_d      = pending_pc_q;
            pending_d = 1'b0;
        end else if (en && ret_pred) begin
            if (count_q != '0) begin
                pc_d = ras_top;
                pop  = 1'b1;
            end else begin
                pc_d   = pc_plus;
                miss_d = 1'b1;
            end
        end else if (en) begin
            pc_d = pc_plus;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (count_q != CW'(RAS_DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VEC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            ptr_q        <= '0;
            count_q      <= '0;
            miss_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            miss_q       <= miss_d;
        end
    end

    // Entries need no reset: they are only read when ras_count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_q[ptr_q] <= link_addr;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each driven cycle queues its expected outputs,
// which are popped and compared just after the following clock edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, exc_valid, redirect_valid, call_valid, ret_pred;
    logic [31:0] redirect_pc, link_addr;
    logic [31:0] pc, pc_plus;
    logic        pending;
    logic [2:0]  ras_count;
    logic        ras_miss;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        pend;
        logic [2:0]  cnt;
        logic        miss;
    } exp_t;

    exp_t sb[$];

    pc_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .exc_valid      (exc_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .call_valid     (call_valid),
        .link_addr      (link_addr),
        .ret_pred       (ret_pred),
        .pc             (pc),
        .pc_plus        (pc_plus),
        .pending        (pending),
        .ras_count      (ras_count),
        .ras_miss       (ras_miss)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        en = 0; exc_valid = 0; redirect_valid = 0; call_valid = 0; ret_pred = 0;
        redirect_pc = '0; link_addr = '0;
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic step(input string tag, input logic e, input logic x, input logic rv,
                        input logic [31:0] rpc, input logic cv, input logic [31:0] link,
                        input logic rp, input logic [31:0] epc, input logic epend,
                        input logic [2:0] ecnt, input logic emiss);
        exp_t item, got;
        en = e; exc_valid = x; redirect_valid = rv; redirect_pc = rpc;
        call_valid = cv; link_addr = link; ret_pred = rp;
        item.tag = tag; item.pc = epc; item.pend = epend; item.cnt = ecnt; item.miss = emiss;
        sb.push_back(item);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_val({got.tag, ".pc"}, pc, got.pc);
        check_val({got.tag, ".pc_plus"}, pc_plus, got.pc + 32'd4);
        check_val({got.tag, ".pending"}, {31'd0, pending}, {31'd0, got.pend});
        check_val({got.tag, ".ras_count"}, {29'd0, ras_count}, {29'd0, got.cnt});
        check_val({got.tag, ".ras_miss"}, {31'd0, ras_miss}, {31'd0, got.miss});
        $display("cycle %-10s pc=%h pending=%0d ras_count=%0d ras_miss=%0d",
                 got.tag, pc, pending, ras_count, ras_miss);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #12;
        check_val("rst.pc", pc, 32'h0000_3000);
        check_val("rst.pending", {31'd0, pending}, 32'd0);
        check_val("rst.ras_count", {29'd0, ras_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step("seq0", 1, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0);
        step("seq1", 1, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0);
        step("cap0", 0, 0, 1, 32'h5000, 1, 32'h77, 0, 32'h3008, 1, 1, 0);

        // Asynchronous reset in the middle of a pending stall with a live RAS entry
        #2;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check_val("arst.pc", pc, 32'h0000_3000);
        check_val("arst.pending", {31'd0, pending}, 32'd0);
        check_val("arst.ras_count", {29'd0, ras_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("arst.hold", pc, 32'h0000_3000);

        step("post0", 1, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0);
        step("post1", 1, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0);
        step("post2", 1, 0, 0, 0, 0, 0, 0, 32'h300C, 0, 0, 0);

        step("stall0", 0, 0, 1, 32'h3100, 0, 0, 0, 32'h300C, 1, 0, 0);
        step("stall1", 0, 0, 0, 0, 0, 0, 1, 32'h300C, 1, 0, 0);
        step("stall2", 0, 0, 1, 32'h3200, 0, 0, 0, 32'h300C, 1, 0, 0);
        step("resume", 1, 0, 0, 0, 0, 0, 0, 32'h3200, 0, 0, 0);

        step("exc0", 0, 0, 1, 32'h3300, 0, 0, 0, 32'h3200, 1, 0, 0);
        step("exc1", 0, 1, 1, 32'h3400, 0, 0, 0, 32'h4180, 0, 0, 0);
        step("exc2", 1, 0, 0, 0, 0, 0, 0, 32'h4184, 0, 0, 0);

        step("call0", 1, 0, 1, 32'h5000, 1, 32'h3010, 0, 32'h5000, 0, 1, 0);
        step("call1", 0, 0, 1, 32'h6000, 1, 32'h3020, 0, 32'h5000, 1, 2, 0);
        step("pendret", 1, 0, 0, 0, 0, 0, 1, 32'h6000, 0, 2, 0);
        step("ret0", 1, 0, 0, 0, 0, 0, 1, 32'h3020, 0, 1, 0);
        step("ret1", 1, 0, 0, 0, 0, 0, 1, 32'h3010, 0, 0, 0);
        step("ret2", 1, 0, 0, 0, 0, 0, 1, 32'h3014, 0, 0, 1);
        step("after", 1, 0, 0, 0, 0, 0, 0, 32'h3018, 0, 0, 0);

        step("callret", 1, 0, 1, 32'h7000, 1, 32'h70, 1, 32'h7000, 0, 1, 0);
        step("excret", 1, 1, 0, 0, 1, 32'h99, 1, 32'h4180, 0, 1, 0);
        step("ret3", 1, 0, 0, 0, 0, 0, 1, 32'h70, 0, 0, 0);
        step("cvonly", 1, 0, 0, 0, 1, 32'h99, 0, 32'h74, 0, 0, 0);

        for (int i = 1; i <= 5; i++) begin
            step($sformatf("ovf%0d", i), 1, 0, 1, 32'h8000, 1, 32'h10 * i, 0,
                 32'h8000, 0, (i > 4) ? 3'd4 : 3'(i), 0);
        end
        for (int i = 0; i < 4; i++) begin
            step($sformatf("pop%0d", i), 1, 0, 0, 0, 0, 0, 1,
                 32'h50 - 32'h10 * i, 0, 3'(3 - i), 0);
        end
        step("popmiss", 1, 0, 0, 0, 0, 0, 1, 32'h24, 0, 0, 1);

        step("wrap0", 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
        step("wrap1", 1, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0);
        step("hold", 0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
